// File: rtl/matmul_nxn_seq.sv
// matmul_nxn_seq
// ----------------------------------------------------------------------------
// Sequential N x N matrix multiplier, C = A x B, one multiply-accumulate per
// cycle. Jobs run back to back: LOAD -> COMPUTE -> OUTPUT -> LOAD.
//
// Parameters:
//   N      matrix dimension (2..4)
//   W      operand element width
//   ACC_W  result element width, derived as 2*W + $clog2(N); do not override
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_data    operand element (A row-major, then B row-major)
//   in_valid   in_data valid
//   in_ready   element accepted this cycle (high only in LOAD)
//   out_data   result element, C row-major (registered)
//   out_valid  out_data valid
//   out_ready  downstream accepts the result this cycle
//   busy       high in COMPUTE and OUTPUT
//   done       one-cycle pulse after the last result is accepted
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds its data and valid stable until the transfer;
// ready never depends on valid.
//
// Build option: define MATMUL_SIGNED_EN for two's-complement operands and a
// sign-extended result. Without it operands and results are unsigned.
// ----------------------------------------------------------------------------
module matmul_nxn_seq #(
  parameter int N     = 3,
  parameter int W     = 8,
  parameter int ACC_W = 2*W + $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int NN    = N * N;
  localparam int CW    = $clog2(N);
  localparam int IDX_W = $clog2(NN);
  localparam int LW    = $clog2(2 * NN);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  // state is kept as a plain named register so checkers can bind to it
  state_t state;
  state_t state_next;

  logic [W-1:0]     a_mem [NN];
  logic [W-1:0]     b_mem [NN];
  logic [ACC_W-1:0] c_mem [NN];

  logic [LW-1:0]    load_cnt;
  logic [CW-1:0]    i_cnt;
  logic [CW-1:0]    j_cnt;
  logic [CW-1:0]    k_cnt;
  logic [IDX_W-1:0] out_cnt;

  logic in_fire;
  logic out_fire;
  logic load_last;
  logic mac_last;
  logic out_last;

  logic [IDX_W-1:0] a_idx;
  logic [IDX_W-1:0] b_idx;
  logic [IDX_W-1:0] c_idx;
  logic [2*W-1:0]   a_ext;
  logic [2*W-1:0]   b_ext;
  logic [2*W-1:0]   prod;
  logic [ACC_W-1:0] prod_ext;

  // Status outputs depend on state alone
  assign in_ready = (state == LOAD);
  assign busy     = (state != LOAD);

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign load_last = (load_cnt == LW'(2 * NN - 1));
  assign mac_last  = (i_cnt == CW'(N - 1)) && (j_cnt == CW'(N - 1)) &&
                     (k_cnt == CW'(N - 1));
  assign out_last  = (out_cnt == IDX_W'(NN - 1));

  // MAC operand addressing and product
  always_comb begin
    a_idx = IDX_W'(int'(i_cnt) * N + int'(k_cnt));
    b_idx = IDX_W'(int'(k_cnt) * N + int'(j_cnt));
    c_idx = IDX_W'(int'(i_cnt) * N + int'(j_cnt));
`ifdef MATMUL_SIGNED_EN
    a_ext    = {{W{a_mem[a_idx][W-1]}}, a_mem[a_idx]};
    b_ext    = {{W{b_mem[b_idx][W-1]}}, b_mem[b_idx]};
    prod     = a_ext * b_ext;
    prod_ext = {{(ACC_W - 2*W){prod[2*W-1]}}, prod};
`else
    a_ext    = {{W{1'b0}}, a_mem[a_idx]};
    b_ext    = {{W{1'b0}}, b_mem[b_idx]};
    prod     = a_ext * b_ext;
    prod_ext = {{(ACC_W - 2*W){1'b0}}, prod};
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (in_fire && load_last)  state_next = COMPUTE;
      COMPUTE: if (mac_last)              state_next = OUTPUT;
      OUTPUT:  if (out_fire && out_last)  state_next = LOAD;
      default:                            state_next = LOAD;
    endcase
  end

  // Operand and result storage; contents are simply overwritten per job
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == LOAD && in_fire) begin
        if (load_cnt < LW'(NN)) a_mem[IDX_W'(load_cnt)] <= in_data;
        else                    b_mem[IDX_W'(load_cnt - LW'(NN))] <= in_data;
      end
      if (state == COMPUTE) begin
        // k == 0 loads the first product so no separate clear is needed
        if (k_cnt == '0) c_mem[c_idx] <= prod_ext;
        else             c_mem[c_idx] <= c_mem[c_idx] + prod_ext;
      end
    end
  end

  // Counters and registered output stream
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt  <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      k_cnt     <= '0;
      out_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          if (in_fire) begin
            if (load_last) load_cnt <= '0;
            else           load_cnt <= load_cnt + LW'(1);
          end
        end
        COMPUTE: begin
          if (k_cnt == CW'(N - 1)) begin
            k_cnt <= '0;
            if (j_cnt == CW'(N - 1)) begin
              j_cnt <= '0;
              if (i_cnt == CW'(N - 1)) i_cnt <= '0;
              else                     i_cnt <= i_cnt + CW'(1);
            end else begin
              j_cnt <= j_cnt + CW'(1);
            end
          end else begin
            k_cnt <= k_cnt + CW'(1);
          end
          // C[0][0] was finished long before the final MAC, so the first
          // result can be registered on the same edge as the last MAC
          if (mac_last) begin
            out_valid <= 1'b1;
            out_data  <= c_mem[0];
            out_cnt   <= '0;
          end
        end
        OUTPUT: begin
          if (out_fire) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              out_cnt   <= '0;
              done      <= 1'b1;
            end else begin
              out_cnt  <= out_cnt + IDX_W'(1);
              out_data <= c_mem[out_cnt + IDX_W'(1)];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_nxn_seq.sv
// tb_matmul_nxn_seq
// ----------------------------------------------------------------------------
// Self-checking bench for matmul_nxn_seq (N=3, W=8). Expected results come
// from a plain arithmetic matrix product kept in the bench; a stream monitor
// compares every accepted result, the hold-while-stalled rule, the first
// result latency and the done pulse.
// ----------------------------------------------------------------------------
module tb_matmul_nxn_seq;

  localparam int N     = 3;
  localparam int W     = 8;
  localparam int ACC_W = 2*W + $clog2(N);
  localparam int NN    = N * N;

  typedef logic [W-1:0] mat_t [NN];

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [W-1:0]     in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             busy;
  logic             done;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  logic [ACC_W-1:0] exp_q[$];

  bit   bp_en    = 1'b0;
  int   bp_phase = 0;
  int   cyc      = 0;
  int   busy_t   = 0;
  int   out_idx  = 0;
  int   done_cnt = 0;
  bit   held_v   = 1'b0;
  logic [ACC_W-1:0] held_d = '0;
  bit   exp_done = 1'b0;
  logic busy_q   = 1'b0;
  logic ov_q     = 1'b0;

  matmul_nxn_seq #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- comparison ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assert_cnt++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint elem_val(input logic [W-1:0] x);
`ifdef MATMUL_SIGNED_EN
    return longint'($signed(x));
`else
    return longint'(x);
`endif
  endfunction

  function automatic void push_expected(input mat_t a, input mat_t b);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint s = 0;
        for (int k = 0; k < N; k++) s += elem_val(a[i*N+k]) * elem_val(b[k*N+j]);
        exp_q.push_back(ACC_W'(s));
      end
    end
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int e = 0; e < NN; e++) m[e] = W'($urandom_range(0, (1 << W) - 1));
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; leaves in_valid high on return.
  task automatic send_elem(input logic [W-1:0] d, output bit ok, output logic dn);
    in_data  = d;
    in_valid = 1'b1;
    ok = 1'b0;
    dn = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (in_ready === 1'b1) begin
        dn = done;
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic send_job(input mat_t a, input mat_t b, input bit release_valid,
                          output logic first_done);
    bit   ok;
    bit   all_ok = 1'b1;
    logic dn;
    first_done = 1'b0;
    for (int e = 0; e < 2*NN; e++) begin
      send_elem((e < NN) ? a[e] : b[e-NN], ok, dn);
      if (e == 0) first_done = dn;
      all_ok &= ok;
    end
    if (release_valid) in_valid = 1'b0;
    check("input_accept", {31'b0, all_ok}, 32'd1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && busy === 1'b0 && out_valid === 1'b0) begin
        idle = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain", {31'b0, idle}, 32'd1);
  endtask

  // out_ready pattern 1,0,0,1 when backpressure is enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_en) begin
        out_ready = (bp_phase == 0) || (bp_phase == 3);
        bp_phase  = (bp_phase + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      held_v   = 1'b0;
      exp_done = 1'b0;
      busy_q   = 1'b0;
      ov_q     = 1'b0;
    end else begin
      check("done_pulse", {31'b0, done}, {31'b0, exp_done});
      if (exp_done) begin
        check("ready_in_done_cycle", {31'b0, in_ready}, 32'd1);
        check("idle_in_done_cycle", {31'b0, busy}, 32'd0);
      end
      exp_done = 1'b0;
      if (held_v) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_data", 32'(out_data), 32'(held_d));
      end
      if (busy === 1'b1 && busy_q !== 1'b1) busy_t = cyc;
      if (out_valid === 1'b1 && ov_q !== 1'b1) check("latency", 32'(cyc - busy_t), 32'(N*N*N));
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_out", {31'b0, out_valid}, 32'd0);
        else                   check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        out_idx++;
        if (out_idx == NN) begin
          out_idx  = 0;
          exp_done = 1'b1;
        end
      end
      held_v = (out_valid === 1'b1) && (out_ready !== 1'b1);
      held_d = out_data;
      busy_q = busy;
      ov_q   = out_valid;
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    mat_t a, b, a2, b2;
    logic fd;
    int   ov_seen;

    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);

    // identity x B (1..9)
    for (int e = 0; e < NN; e++) begin
      a[e] = ((e / N) == (e % N)) ? W'(1) : W'(0);
      b[e] = W'(e + 1);
    end
    push_expected(a, b);
    send_job(a, b, 1'b1, fd);
    wait_idle();
    check("done_count_identity", 32'(done_cnt), 32'd1);

`ifdef MATMUL_SIGNED_EN
    // all -128
    for (int e = 0; e < NN; e++) begin
      a[e] = 8'h80;
      b[e] = 8'h80;
    end
    push_expected(a, b);
    send_job(a, b, 1'b1, fd);
    wait_idle();
    // -I x (1..9)
    for (int e = 0; e < NN; e++) begin
      a[e] = ((e / N) == (e % N)) ? 8'hFF : 8'h00;
      b[e] = W'(e + 1);
    end
    push_expected(a, b);
    send_job(a, b, 1'b1, fd);
    wait_idle();
`else
    // all 255
    for (int e = 0; e < NN; e++) begin
      a[e] = 8'hFF;
      b[e] = 8'hFF;
    end
    push_expected(a, b);
    send_job(a, b, 1'b1, fd);
    wait_idle();
`endif

    // same random job without and with backpressure
    a = rand_mat();
    b = rand_mat();
    push_expected(a, b);
    send_job(a, b, 1'b1, fd);
    wait_idle();
    bp_phase = 0;
    bp_en    = 1'b1;
    push_expected(a, b);
    send_job(a, b, 1'b1, fd);
    wait_idle();
    bp_en = 1'b0;

    // reset during COMPUTE at MAC 10: the job is discarded
    a = rand_mat();
    b = rand_mat();
    send_job(a, b, 1'b1, fd);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    ov_seen = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ov_seen++;
    end
    @(posedge clk); #1;
    check("midrst_no_output", 32'(ov_seen), 32'd0);
    a = rand_mat();
    b = rand_mat();
    push_expected(a, b);
    send_job(a, b, 1'b1, fd);
    wait_idle();

    // back-to-back with in_valid held high between jobs
    a  = rand_mat();
    b  = rand_mat();
    a2 = rand_mat();
    b2 = rand_mat();
    push_expected(a, b);
    push_expected(a2, b2);
    done_cnt = 0;
    send_job(a, b, 1'b0, fd);
    send_job(a2, b2, 1'b1, fd);
    check("b2b_first_accept_in_done_cycle", {31'b0, fd}, 32'd1);
    wait_idle();
    check("b2b_done_count", 32'(done_cnt), 32'd2);

    // a few random jobs with random backpressure phase
    for (int r = 0; r < 3; r++) begin
      a = rand_mat();
      b = rand_mat();
      push_expected(a, b);
      bp_phase = int'($urandom_range(0, 3));
      bp_en    = ($urandom_range(0, 1) == 1);
      send_job(a, b, 1'b1, fd);
      wait_idle();
      bp_en = 1'b0;
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
